udp_rx_frame_fifo: RTL and testbench

UDP_RX_FRAME_FIFO -- requirements
Module: udp_rx_frame_fifo

---
 rtl/udp_rx_fifo_pkg.sv | 18 +
 rtl/sdp_ram.sv | 35 +++
 rtl/udp_rx_frame_fifo.sv | 162 ++++++++++++++++
 tb/tb_udp_rx_frame_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_fifo_pkg.sv
// Shared definitions for the UDP receive frame FIFO:
// entry layout (data/keep/last) and write-FSM state encoding.
package udp_rx_fifo_pkg;

    localparam int DATA_W   = 64;
    localparam int KEEP_W   = 8;
    localparam int DATA_LSB = 0;
    localparam int KEEP_LSB = DATA_LSB + DATA_W;
    localparam int LAST_BIT = KEEP_LSB + KEEP_W;
    localparam int ENTRY_W  = LAST_BIT + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports: clk, we/waddr/wdata (write), re/raddr/rdata (read, 1-cycle).
module sdp_ram #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 73,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data only updates on re, so a stalled entry stays put.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/udp_rx_frame_fifo.sv
// Store-and-forward frame FIFO behind a UDP RX stream (no tready upstream).
// Ports: s_axis_* in, m_axis_* out, frame_avail, drop_cnt, overflow.
module udp_rx_frame_fifo
    import udp_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic             rx_axis_aclk,
    input  logic             rx_axis_aresetn,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             frame_avail,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] FULL_V = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P  = PTR_W'(1);

    wr_state_e          state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   cm_ptr_q, cm_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   fe_ptr_q, fe_ptr_d;
    logic               ram_vld_q, ram_vld_d;
    logic               out_vld_q, out_vld_d;
    logic [ENTRY_W-1:0] out_ent_q, out_ent_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               ovf_q, ovf_d;

    logic               full;
    logic [CNT_W-1:0]   drop_inc;
    logic               ram_we;
    logic               ram_re;
    logic [ENTRY_W-1:0] ram_wdata;
    logic [ENTRY_W-1:0] ram_rdata;
    logic               out_rdy;
    logic               mv;
    logic               pop;

    // rd_ptr only advances on an output handshake, so entries
    // prefetched into the RAM/output stages still occupy space.
    assign full     = (wr_ptr_q - rd_ptr_q) == FULL_V;
    assign drop_inc = (drop_cnt_q == '1) ? drop_cnt_q
                                         : drop_cnt_q + CNT_W'(1);

    assign ram_wdata = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = 1'b0;
        ram_we     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast && s_axis_tuser) begin
                        wr_ptr_d   = cm_ptr_q;
                        drop_cnt_d = drop_inc;
                        state_d    = ST_IDLE;
                    end else if (full) begin
                        wr_ptr_d   = cm_ptr_q;
                        drop_cnt_d = drop_inc;
                        ovf_d      = 1'b1;
                        state_d    = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        if (s_axis_tlast) begin
                            cm_ptr_d = wr_ptr_q + ONE_P;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Two-stage read: RAM register then output register, with the
    // RAM stage refilled whenever it is empty or draining.
    always_comb begin
        out_rdy   = !out_vld_q || m_axis_tready;
        mv        = ram_vld_q && out_rdy;
        ram_re    = (!ram_vld_q || mv) && (cm_ptr_q != fe_ptr_q);
        pop       = out_vld_q && m_axis_tready;
        fe_ptr_d  = ram_re ? fe_ptr_q + ONE_P : fe_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + ONE_P : rd_ptr_q;
        ram_vld_d = ram_re || (ram_vld_q && !mv);
        out_vld_d = mv || (out_vld_q && !m_axis_tready);
        out_ent_d = mv ? ram_rdata : out_ent_q;
    end

    always_ff @(posedge rx_axis_aclk) begin
        if (!rx_axis_aresetn) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fe_ptr_q   <= '0;
            ram_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_ent_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fe_ptr_q   <= fe_ptr_d;
            ram_vld_q  <= ram_vld_d;
            out_vld_q  <= out_vld_d;
            out_ent_q  <= out_ent_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (rx_axis_aclk),
        .we   (ram_we),
        .waddr(wr_ptr_q[ADDR_W-1:0]),
        .wdata(ram_wdata),
        .re   (ram_re),
        .raddr(fe_ptr_q[ADDR_W-1:0]),
        .rdata(ram_rdata)
    );

    assign m_axis_tdata  = out_ent_q[DATA_LSB +: DATA_W];
    assign m_axis_tkeep  = out_ent_q[KEEP_LSB +: KEEP_W];
    assign m_axis_tlast  = out_ent_q[LAST_BIT];
    assign m_axis_tvalid = out_vld_q;
    assign frame_avail   = (cm_ptr_q != rd_ptr_q) || out_vld_q;
    assign drop_cnt      = drop_cnt_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_udp_rx_frame_fifo.sv
// Directed bench for udp_rx_frame_fifo with a beat scoreboard.
// DUT built with DEPTH=16, CNT_W=3 so full and saturation are reachable.
module tb_udp_rx_frame_fifo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tuser;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        frame_avail;
    logic [2:0]  drop_cnt;
    logic        overflow;

    logic tready_man = 1'b1;
    logic rnd_ready  = 1'b0;
    logic rand_en    = 1'b0;
    assign m_tready = rand_en ? rnd_ready : tready_man;

    int vectors     = 0;
    int miscompares = 0;
    int ovf_cnt     = 0;
    int out_cnt     = 0;

    logic [72:0] sb [$];
    logic        prev_stall = 1'b0;
    logic [72:0] prev_ent;

    udp_rx_frame_fifo #(
        .DEPTH(16),
        .CNT_W(3)
    ) dut (
        .rx_axis_aclk   (clk),
        .rx_axis_aresetn(rst_n),
        .s_axis_tdata   (s_tdata),
        .s_axis_tkeep   (s_tkeep),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tlast   (s_tlast),
        .s_axis_tuser   (s_tuser),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .frame_avail    (frame_avail),
        .drop_cnt       (drop_cnt),
        .overflow       (overflow)
    );

    task automatic check(input string tag, input logic [72:0] obs,
                         input logic [72:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        logic [72:0] cur;
        logic [72:0] e;
        cur = {m_tlast, m_tkeep, m_tdata};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (overflow) ovf_cnt++;
            if (prev_stall) begin
                check("stall_valid", 73'(m_tvalid), 73'(1));
                check("stall_data", cur, prev_ent);
            end
            if (m_tvalid && m_tready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    vectors++;
                    assert (sb.size() != 0) else begin
                        miscompares++;
                        $error("FAIL extra_beat observed=%h expected=none",
                               cur);
                    end
                end else begin
                    e = sb.pop_front();
                    check("out_beat", cur, e);
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_ent   = cur;
        end
    end

    task automatic beat(input logic [63:0] d, input logic [7:0] k,
                        input logic l, input logic u);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int tag,
                              input logic [7:0] lk, input logic err,
                              input logic push);
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        for (int i = 0; i < n; i++) begin
            d = {tag, i};
            l = (i == n - 1);
            k = l ? lk : 8'hFF;
            if (push) sb.push_back({l, k, d});
            beat(d, k, l, err && l);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 73'(sb.size() == 0), 73'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int w;
        int n;
        logic [7:0] lk;

        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 73'(m_tvalid), 73'(0));
        check("rst_avail", 73'(frame_avail), 73'(0));
        check("rst_drop", 73'(drop_cnt), 73'(0));
        check("rst_ovf", 73'(overflow), 73'(0));
        check("rst_data", {m_tlast, m_tkeep, m_tdata}, 73'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        s_tdata = 64'hDEAD_BEEF_0000_0001;
        s_tkeep = 8'hFF;
        s_tlast = 1'b1;
        s_tuser = 1'b1;
        @(posedge clk);
        #1;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("novalid_avail", 73'(frame_avail), 73'(0));
        check("novalid_drop", 73'(drop_cnt), 73'(0));
        check("novalid_tvalid", 73'(m_tvalid), 73'(0));

        send_frame(3, 1, 8'h0F, 1'b0, 1'b1);
        check("commit_avail", 73'(frame_avail), 73'(1));
        check("lat_t0", 73'(m_tvalid), 73'(0));
        @(posedge clk);
        #1;
        check("lat_t1", 73'(m_tvalid), 73'(0));
        @(posedge clk);
        #1;
        check("lat_t2", 73'(m_tvalid), 73'(1));
        drain("good3_drain");
        check("good3_drop", 73'(drop_cnt), 73'(0));

        send_frame(4, 2, 8'hFF, 1'b1, 1'b0);
        send_frame(2, 3, 8'h3F, 1'b0, 1'b1);
        drain("err_drain");
        check("err_drop", 73'(drop_cnt), 73'(1));
        check("err_ovf", 73'(ovf_cnt), 73'(0));

        tready_man = 1'b0;
        send_frame(10, 4, 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            beat({32'd5, i}, 8'hFF, i == 9, 1'b0);
            if (i == 5) check("ovf_b6", 73'(overflow), 73'(0));
            if (i == 6) check("ovf_b7", 73'(overflow), 73'(1));
            if (i == 7) check("ovf_b8", 73'(overflow), 73'(0));
        end
        repeat (4) @(posedge clk);
        #1;
        check("full_drop", 73'(drop_cnt), 73'(2));
        check("full_ovf", 73'(ovf_cnt), 73'(1));
        check("full_tvalid", 73'(m_tvalid), 73'(1));
        base = out_cnt;
        tready_man = 1'b1;
        drain("full_drain");
        check("full_out_cnt", 73'(out_cnt - base), 73'(10));

        rand_en = 1'b1;
        for (int f = 0; f < 20; f++) begin
            w = 0;
            while (sb.size() > 8 && w < 300) begin
                @(posedge clk);
                #1;
                w++;
            end
            check("rand_space", 73'(sb.size() <= 8), 73'(1));
            n  = $urandom_range(1, 5);
            lk = 8'hFF >> $urandom_range(0, 7);
            send_frame(n, 100 + f, lk, 1'b0, 1'b1);
        end
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        rand_en = 1'b0;
        drain("rand_drain");
        check("rand_drop", 73'(drop_cnt), 73'(2));

        tready_man = 1'b0;
        send_frame(1, 200, 8'hFF, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        beat({32'd201, 32'd0}, 8'hFF, 1'b0, 1'b0);
        s_tdata  = {32'd201, 32'd1};
        s_tvalid = 1'b1;
        rst_n    = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_tvalid", 73'(m_tvalid), 73'(0));
        check("mid_rst_avail", 73'(frame_avail), 73'(0));
        check("mid_rst_drop", 73'(drop_cnt), 73'(0));
        tready_man = 1'b1;
        send_frame(1, 202, 8'h07, 1'b0, 1'b1);
        drain("post_rst_drain");
        check("post_rst_drop", 73'(drop_cnt), 73'(0));

        for (int i = 0; i < 7; i++) begin
            send_frame(1, 300 + i, 8'hFF, 1'b1, 1'b0);
        end
        check("sat_max", 73'(drop_cnt), 73'(7));
        send_frame(1, 400, 8'hFF, 1'b1, 1'b0);
        check("sat_hold", 73'(drop_cnt), 73'(7));
        check("sat_avail", 73'(frame_avail), 73'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
